// File: rtl/audioplay_input_conditioner.sv
// audioplay_input_conditioner: synchronizes and debounces switch/button pins and exposes DATA/EDGE/MASK/RAW over Avalon-MM.
// Define AUDIOPLAY_INCOND_IRQ_EN to build the MASK register and irq; otherwise addr 2 reads 0 and irq is tied low.
module audioplay_input_conditioner #(
    parameter int N_INPUTS        = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [N_INPUTS-1:0] raw_in,
    output logic [N_INPUTS-1:0] clean_out,
    input  logic [1:0]          avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    output logic                irq
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_INPUTS-1:0] meta_q, sync_q, clean_q, clean_d, edge_q, edge_d, edge_set, w1c, mask_q;
    logic [CNT_W-1:0]    cnt_q [N_INPUTS];
    logic [CNT_W-1:0]    cnt_d [N_INPUTS];
    logic [31:0]         rdata_q, rdata_d;

    // A channel's change is accepted on the cycle its count is already at LAST and still mismatched
    always_comb begin
        for (int c = 0; c < N_INPUTS; c++) begin
            edge_set[c] = (sync_q[c] != clean_q[c]) && (cnt_q[c] == LAST);
            cnt_d[c]    = (sync_q[c] == clean_q[c] || edge_set[c]) ? '0 : cnt_q[c] + 1'b1;
        end
        clean_d = clean_q ^ edge_set;
        w1c     = (avs_write && avs_address == 2'd1) ? avs_writedata[N_INPUTS-1:0] : '0;
        edge_d  = (edge_q & ~w1c) | edge_set;
        rdata_d = !avs_read              ? rdata_q :
                  avs_address == 2'd0    ? 32'(clean_q) :
                  avs_address == 2'd1    ? 32'(edge_q) :
                  avs_address == 2'd2    ? 32'(mask_q) : 32'(sync_q);
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            meta_q  <= '0;
            sync_q  <= '0;
            clean_q <= '0;
            edge_q  <= '0;
            rdata_q <= '0;
            for (int c = 0; c < N_INPUTS; c++) cnt_q[c] <= '0;
        end else begin
            meta_q  <= raw_in;
            sync_q  <= meta_q;
            clean_q <= clean_d;
            edge_q  <= edge_d;
            rdata_q <= rdata_d;
            for (int c = 0; c < N_INPUTS; c++) cnt_q[c] <= cnt_d[c];
        end
    end

`ifdef AUDIOPLAY_INCOND_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= (avs_write && avs_address == 2'd2) ? avs_writedata[N_INPUTS-1:0] : mask_q;
            irq_q  <= |(edge_q & mask_q);
        end
    end

    assign irq = irq_q;
`else
    assign mask_q = '0;
    assign irq    = 1'b0;
`endif

    assign clean_out    = clean_q;
    assign avs_readdata = rdata_q;
endmodule

// File: tb/tb_audioplay_input_conditioner.sv
// tb_audioplay_input_conditioner: directed checks of debounce timing, EDGE/W1C, MASK/irq and reset with DEBOUNCE_CYCLES=4.
module tb_audioplay_input_conditioner;
    localparam int N = 3;
`ifdef AUDIOPLAY_INCOND_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic         clk_clk       = 1'b0;
    logic         reset_reset_n = 1'b0;
    logic [N-1:0] raw_in        = '0;
    logic [N-1:0] clean_out;
    logic [1:0]   avs_address   = '0;
    logic         avs_read      = 1'b0;
    logic         avs_write     = 1'b0;
    logic [31:0]  avs_writedata = '0;
    logic [31:0]  avs_readdata, rd;
    logic         irq;
    int           n_tests = 0, n_fail = 0;

    audioplay_input_conditioner #(.N_INPUTS(N), .DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .raw_in(raw_in), .clean_out(clean_out),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .irq(irq)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        tick();
        avs_write = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        tick();
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    initial begin
        tick(3);
        check("rst_clean", 32'(clean_out), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_rdata", avs_readdata, 0);
        reset_reset_n = 1'b1;
        for (int a = 0; a < 3; a++) begin
            bus_rd(2'(a), rd);
            check($sformatf("rst_rd%0d", a), rd, 0);
        end
        bus_wr(2'd2, 32'h1);
        bus_rd(2'd2, rd);
        check("mask_rd", rd, IRQ_EN ? 32'h1 : 32'h0);
        bus_wr(2'd0, 32'h7);
        bus_rd(2'd0, rd);
        check("data_ro", rd, 0);
        // clean step on channel 0
        raw_in[0] = 1'b1;
        tick(5);
        check("step_c5", 32'(clean_out), 32'b000);
        tick();
        check("step_c6", 32'(clean_out), 32'b001);
        check("step_irq_c6", 32'(irq), 0);
        tick();
        check("step_irq_c7", 32'(irq), 32'(IRQ_EN));
        bus_rd(2'd3, rd);
        check("raw_rd", rd, 32'h1);
        bus_rd(2'd1, rd);
        check("step_edge", rd, 32'h1);
        bus_wr(2'd1, 32'h1);
        check("w1c_irq_wr", 32'(irq), 32'(IRQ_EN));
        tick();
        check("w1c_irq_next", 32'(irq), 0);
        bus_rd(2'd1, rd);
        check("w1c_edge", rd, 0);
        // glitch on channel 1
        raw_in[1] = 1'b1;
        tick(3);
        raw_in[1] = 1'b0;
        tick(8);
        check("glitch_clean", 32'(clean_out), 32'b001);
        bus_rd(2'd1, rd);
        check("glitch_edge", rd, 0);
        // bounce on channel 2
        raw_in[2] = 1'b1; tick();
        raw_in[2] = 1'b0; tick();
        raw_in[2] = 1'b1; tick();
        raw_in[2] = 1'b0; tick();
        raw_in[2] = 1'b1;
        tick(5);
        check("bounce_c5", 32'(clean_out), 32'b001);
        tick();
        check("bounce_c6", 32'(clean_out), 32'b101);
        bus_rd(2'd1, rd);
        check("bounce_edge", rd, 32'h4);
        bus_wr(2'd1, 32'h4);
        // channel 0 falls, arming EDGE[0]
        raw_in[0] = 1'b0;
        tick(6);
        check("fall_clean", 32'(clean_out), 32'b100);
        // channel 0 rises; W1C lands on the completing edge
        raw_in[0] = 1'b1;
        tick(5);
        bus_wr(2'd1, 32'h1);
        check("race_clean", 32'(clean_out), 32'b101);
        tick();
        check("race_irq", 32'(irq), 32'(IRQ_EN));
        bus_rd(2'd1, rd);
        check("race_edge", rd, 32'h1);
        bus_wr(2'd1, 32'h1);
        check("race2_irq_wr", 32'(irq), 32'(IRQ_EN));
        tick();
        check("race2_irq_next", 32'(irq), 0);
        bus_rd(2'd1, rd);
        check("race2_edge", rd, 0);
        // reset mid-count discards progress
        raw_in[1] = 1'b1;
        tick(4);
        reset_reset_n = 1'b0;
        tick();
        reset_reset_n = 1'b1;
        check("midrst_clean", 32'(clean_out), 0);
        bus_rd(2'd1, rd);
        check("midrst_edge", rd, 0);
        tick(4);
        check("midrst_c5", 32'(clean_out), 0);
        tick();
        check("midrst_c6", 32'(clean_out), 32'b111);
        bus_rd(2'd1, rd);
        check("midrst_edge2", rd, 32'h7);
        // all inputs toggle with MASK written to 7
        bus_wr(2'd1, 32'h7);
        bus_wr(2'd2, 32'h7);
        raw_in = '0;
        tick(6);
        check("all_clean", 32'(clean_out), 0);
        bus_rd(2'd1, rd);
        check("all_edge", rd, 32'h7);
        check("all_irq", 32'(irq), 32'(IRQ_EN));
        bus_rd(2'd2, rd);
        check("all_mask", rd, IRQ_EN ? 32'h7 : 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
